// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM bus widths and the ROM access controller state encoding.
package cpu_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2
    } rom_state_t;

endpackage

// File: rtl/rom_access_ctrl.sv
// Arbitrates instruction-fetch and data-load ports onto a single ROM,
// with a starvation counter that eventually forces the low-priority port through.
module rom_access_ctrl
    import cpu_pkg::*;
#(
    parameter int DL_PRIORITY = 1,
    parameter int MAX_WAIT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ROM_ADDR_W-1:0] if_addr,
    output logic                  if_ack,
    output logic [ROM_DATA_W-1:0] if_data,
    input  logic                  dl_req,
    input  logic [ROM_ADDR_W-1:0] dl_addr,
    output logic                  dl_ack,
    output logic [ROM_DATA_W-1:0] dl_data,
    output logic                  rom_ena,
    output logic                  rom_read,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_DATA_W-1:0] rom_data,
    output logic                  busy
);

    localparam logic       HI_IS_DL   = (DL_PRIORITY != 0);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    rom_state_t state, state_nxt;
    logic       win_dl;
    logic       grant_dl;
    logic       contend;
    logic       any_req;
    logic       low_wins;
    logic [3:0] wait_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = RD;
            RD:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A lone requester always wins; under contention the starvation limit flips the winner.
    always_comb begin
        any_req  = if_req | dl_req;
        contend  = if_req & dl_req;
        grant_dl = dl_req;
        if (contend) begin
            grant_dl = HI_IS_DL ? (wait_cnt != WAIT_LIMIT) : (wait_cnt == WAIT_LIMIT);
        end
        low_wins = (grant_dl != HI_IS_DL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            win_dl   <= 1'b0;
            wait_cnt <= 4'd0;
            rom_addr <= '0;
            if_data  <= '0;
            dl_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                rom_addr <= grant_dl ? dl_addr : if_addr;
                win_dl   <= grant_dl;
                if (low_wins) begin
                    wait_cnt <= 4'd0;
                end else if (contend && wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
            end
            if (state == RD) begin
                if (win_dl) dl_data <= rom_data;
                else        if_data <= rom_data;
            end
        end
    end

    assign rom_ena  = (state == RD);
    assign rom_read = (state == RD);
    assign busy     = (state != IDLE);
    assign if_ack   = (state == ACK) && !win_dl;
    assign dl_ack   = (state == ACK) &&  win_dl;

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Directed bench for rom_access_ctrl with a small behavioural ROM on the data bus.
module tb_rom_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       if_req, dl_req;
    logic [7:0] if_addr, dl_addr;
    logic       if_ack, dl_ack;
    logic [7:0] if_data, dl_data;
    logic       rom_ena, rom_read, busy;
    logic [7:0] rom_addr;
    wire  [7:0] rom_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [7:0] a);
        case (a)
            8'h01:   return 8'h11;
            8'h03:   return 8'h41;
            8'h81:   return 8'h64;
            8'h82:   return 8'h32;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    assign rom_data = (rom_ena && rom_read) ? rom_word(rom_addr) : 8'hzz;

    rom_access_ctrl #(.DL_PRIORITY(1), .MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_ack(dl_ack), .dl_data(dl_data),
        .rom_ena(rom_ena), .rom_read(rom_read), .rom_addr(rom_addr),
        .rom_data(rom_data), .busy(busy)
    );

    task automatic apply_reset();
        rst_n = 1'b0; if_req = 1'b0; dl_req = 1'b0; if_addr = 8'h00; dl_addr = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [28:0] obs;
        rst_n = 1'b0; if_req = 1'b0; dl_req = 1'b0; if_addr = 8'h00; dl_addr = 8'h00;
        repeat (2) @(negedge clk);
        obs = {busy, rom_ena, rom_read, if_ack, dl_ack, rom_addr, if_data, dl_data};
        total++;
        if (obs !== 29'd0) begin
            bad++; $display("FAIL reset_held: got %h want 0", obs);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs = {busy, rom_ena, rom_read, if_ack, dl_ack, rom_addr, if_data, dl_data};
            total++;
            if (obs !== 29'd0) begin
                bad++; $display("FAIL reset_idle cycle %0d: got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_if_fetch();
        @(negedge clk);
        if_addr = 8'h01; if_req = 1'b1;
        @(negedge clk);
        total++;
        if ({rom_ena, rom_read, busy, if_ack, rom_addr} !== {4'b1110, 8'h01}) begin
            bad++; $display("FAIL if_rd: ena/read/busy/ack=%b%b%b%b addr=%h want 1110 01",
                            rom_ena, rom_read, busy, if_ack, rom_addr);
        end
        @(negedge clk);
        total++;
        if ({if_ack, dl_ack, rom_ena, if_data, dl_data} !== {3'b100, 8'h11, 8'h00}) begin
            bad++; $display("FAIL if_ack: ack=%b dlack=%b ena=%b if_data=%h dl_data=%h want 1 0 0 11 00",
                            if_ack, dl_ack, rom_ena, if_data, dl_data);
        end
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if ({if_ack, busy} !== 2'b00) begin
            bad++; $display("FAIL if_done: ack=%b busy=%b want 0 0", if_ack, busy);
        end
    endtask

    task automatic test_contention();
        int n_ack = 0;
        logic first_dl = 1'b0;
        @(negedge clk);
        if_addr = 8'h03; dl_addr = 8'h81; if_req = 1'b1; dl_req = 1'b1;
        for (int c = 0; c < 20 && n_ack < 2; c++) begin
            @(negedge clk);
            total++;
            if (if_ack && dl_ack) begin
                bad++; $display("FAIL contend_overlap: both acks high at cycle %0d", c);
            end
            if (dl_ack) begin
                if (n_ack == 0) first_dl = 1'b1;
                n_ack++; dl_req = 1'b0;
            end else if (if_ack) begin
                n_ack++; if_req = 1'b0;
            end
        end
        total++;
        if (n_ack != 2 || first_dl !== 1'b1) begin
            bad++; $display("FAIL contend_order: acks=%0d first_dl=%b want 2 1", n_ack, first_dl);
        end
        total++;
        if ({dl_data, if_data} !== {8'h64, 8'h41}) begin
            bad++; $display("FAIL contend_data: dl=%h if=%h want 64 41", dl_data, if_data);
        end
        if_req = 1'b0; dl_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        logic exp_dl [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int n = 0;
        apply_reset();
        if_addr = 8'h01; dl_addr = 8'h81; if_req = 1'b1; dl_req = 1'b1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (if_ack || dl_ack) begin
                total++;
                if (dl_ack !== exp_dl[n] || if_ack === dl_ack) begin
                    bad++; $display("FAIL fair_grant %0d: dl_ack=%b if_ack=%b want dl=%b",
                                    n, dl_ack, if_ack, exp_dl[n]);
                end
                n++;
            end
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL fair_timeout: grants=%0d want 8", n);
        end
        if_req = 1'b0; dl_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_addr_hold();
        @(negedge clk);
        dl_addr = 8'h82; dl_req = 1'b1;
        @(negedge clk);
        dl_addr = 8'h00; if_addr = 8'h03; if_req = 1'b1;
        total++;
        if (rom_addr !== 8'h82) begin
            bad++; $display("FAIL hold_addr: rom_addr=%h want 82", rom_addr);
        end
        @(negedge clk);
        total++;
        if ({dl_ack, if_ack, dl_data, if_data} !== {2'b10, 8'h32, 8'h11}) begin
            bad++; $display("FAIL hold_data: dl_ack=%b if_ack=%b dl=%h if=%h want 1 0 32 11",
                            dl_ack, if_ack, dl_data, if_data);
        end
        dl_req = 1'b0; if_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({if_ack, dl_ack, busy} !== 3'b000) begin
                bad++; $display("FAIL withdrawn_req cycle %0d: if_ack=%b dl_ack=%b busy=%b want 000",
                                i, if_ack, dl_ack, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dl_addr = 8'h81; dl_req = 1'b1;
        @(negedge clk);
        total++;
        if (rom_ena !== 1'b1) begin
            bad++; $display("FAIL mid_rd: rom_ena=%b want 1", rom_ena);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rom_ena, rom_read, busy, dl_data} !== {3'b000, 8'h00}) begin
            bad++; $display("FAIL mid_async: ena=%b read=%b busy=%b dl=%h want 0 0 0 00",
                            rom_ena, rom_read, busy, dl_data);
        end
        @(negedge clk);
        dl_req = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if ({dl_ack, if_ack, busy} !== 3'b000) begin
                bad++; $display("FAIL mid_noack cycle %0d: dl_ack=%b if_ack=%b busy=%b want 000",
                                i, dl_ack, if_ack, busy);
            end
        end
        total++;
        if (dl_data !== 8'h00) begin
            bad++; $display("FAIL mid_data: dl_data=%h want 00", dl_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_if_fetch();
        test_contention();
        test_fairness();
        test_addr_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_access_ctrl.md
ROM_ACCESS_CTRL -- requirements
Module: rom_access_ctrl

Interface
REQ-001 Parameter DL_PRIORITY, default 1: 1 = data-load port wins contention, 0 = instruction-fetch port wins.
REQ-002 Parameter MAX_WAIT, default 3, range 1..15: consecutive lost arbitrations after which the low-priority port is forced to win.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-007 if_addr  input  8  instruction-fetch ROM address.
REQ-008 if_ack  output  1  one-cycle pulse: if_data valid.
REQ-009 if_data  output  8  fetched byte, held until next if_ack.
REQ-010 dl_req  input  1  data-load (LDO operand) request, level, held until dl_ack.
REQ-011 dl_addr  input  8  data-load ROM address.
REQ-012 dl_ack  output  1  one-cycle pulse: dl_data valid.
REQ-013 dl_data  output  8  loaded byte, held until next dl_ack.
REQ-014 rom_ena  output  1  ROM enable.
REQ-015 rom_read  output  1  ROM read strobe.
REQ-016 rom_addr  output  8  ROM address.
REQ-017 rom_data  input  8  ROM read data; high-Z unless rom_ena and rom_read both high.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, RD, ACK; IDLE->RD when any request sampled high; RD->ACK unconditionally; ACK->IDLE unconditionally.
REQ-020 On IDLE->RD the winner's address shall be latched into rom_addr and the winner recorded; address changes after that edge are ignored.
REQ-021 rom_ena and rom_read shall both be high exactly during RD and low in every other state.
REQ-022 On RD->ACK, rom_data shall be captured into the winner's data register only; the other port's data register is unchanged.
REQ-023 The winner's ack shall be high exactly during ACK (one cycle); latency from request-sampling edge to ack high is two cycles.
REQ-024 Requesters drop req on the edge sampling ack; requests are not sampled in RD or ACK, so peak throughput is one access per three cycles.
REQ-025 Single request in IDLE: that port wins regardless of DL_PRIORITY.
REQ-026 Both requests in IDLE: high-priority port wins unless wait counter == MAX_WAIT, then low-priority port wins.
REQ-027 Wait counter (4 bits) increments, saturating at MAX_WAIT, on each contention the low-priority port loses; clears to 0 when the low-priority port wins; unchanged otherwise.
REQ-028 Request withdrawn before being sampled in IDLE: no access, no ack, counter unchanged.
REQ-029 if_ack and dl_ack shall never be high in the same cycle.

Reset
REQ-030 While rst_n low: state IDLE; rom_ena, rom_read, if_ack, dl_ack, busy = 0; rom_addr, if_data, dl_data = 0x00; wait counter = 0; effective immediately (asynchronous), including mid-access.
REQ-031 An access interrupted by reset shall produce no ack after reset release; the requester must re-request.

Structure
REQ-032 FSM state enum (IDLE, RD, ACK), ROM_ADDR_W = 8 and ROM_DATA_W = 8 belong in the shared cpu_pkg package.
REQ-033 Single module; no sub-module; arbitration and counter are inline.

Verification
REQ-034 Reset: rst_n low, then released with no requests -> all outputs 0, busy 0 for 10 cycles.
REQ-035 if_req with if_addr=0x01 -> rom_ena/rom_read high one cycle with rom_addr=0x01, if_ack one cycle later with if_data=0x11, dl_data unchanged.
REQ-036 if_req(0x03) and dl_req(0x81) in the same cycle, DL_PRIORITY=1 -> dl_ack first with dl_data=0x64, then if_ack with if_data=0x41; acks never overlap.
REQ-037 Both ports requesting continuously, DL_PRIORITY=1, MAX_WAIT=3 -> grant order DL, DL, DL, IF, DL, DL, DL, IF, ...
REQ-038 dl_req(0x82) with dl_addr changed to 0x00 during RD -> dl_data=0x32.
REQ-039 rst_n pulsed low during RD -> rom_ena drops immediately, no ack after release, dl_data=0x00.
